// File: rtl/aes_pkg.sv
// Shared constants and types for the 256-bit Rijndael ShiftRows datapath.
// Row offsets are the forward (encrypt) rotate-left amounts in bytes.
package aes_pkg;

  localparam int NB = 8;

  localparam logic [2:0] SR_OFF_ROW0 = 3'd4;
  localparam logic [2:0] SR_OFF_ROW1 = 3'd3;
  localparam logic [2:0] SR_OFF_ROW2 = 3'd1;
  localparam logic [2:0] SR_OFF_ROW3 = 3'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sr_state_e;

  function automatic logic [2:0] sr_row_offset(input logic [1:0] row);
    logic [2:0] off;
    case (row)
      2'd0:    off = SR_OFF_ROW0;
      2'd1:    off = SR_OFF_ROW1;
      2'd2:    off = SR_OFF_ROW2;
      default: off = SR_OFF_ROW3;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/row_rotl64.sv
// Combinational 64-bit rotate-left by a whole number of bytes (0..7).
// The MSB byte of the input wraps around to the LSB position.
module row_rotl64 (
  input  logic [63:0] data_i,
  input  logic [2:0]  off_i,
  output logic [63:0] data_o
);

  always_comb begin
    case (off_i)
      3'd0:    data_o = data_i;
      3'd1:    data_o = {data_i[55:0], data_i[63:56]};
      3'd2:    data_o = {data_i[47:0], data_i[63:48]};
      3'd3:    data_o = {data_i[39:0], data_i[63:40]};
      3'd4:    data_o = {data_i[31:0], data_i[63:32]};
      3'd5:    data_o = {data_i[23:0], data_i[63:24]};
      3'd6:    data_o = {data_i[15:0], data_i[63:16]};
      default: data_o = {data_i[7:0],  data_i[63:8]};
    endcase
  end

endmodule

// File: rtl/shiftrow256_seq.sv
// Sequential forward ShiftRows for a 256-bit state: one row per clock through
// a single shared 64-bit byte rotator, with a valid/ready handshake on each side.
module shiftrow256_seq #(
  parameter int NB = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] sl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] sr
);

  import aes_pkg::*;

  if (NB != aes_pkg::NB) begin : g_nb_check
    $error("shiftrow256_seq supports only NB = 8");
  end

  sr_state_e    state_q, state_d;
  logic [1:0]   cnt_q,   cnt_d;
  logic [255:0] data_q,  data_d;
  logic [63:0]  rot_in,  rot_out;

  assign rot_in = data_q[{cnt_q, 6'b0} +: 64];

  row_rotl64 u_rotl (
    .data_i (rot_in),
    .off_i  (sr_row_offset(cnt_q)),
    .data_o (rot_out)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = sl;
          cnt_d   = 2'd3;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        data_d[{cnt_q, 6'b0} +: 64] = rot_out;
        // Row 0 is the last row; the counter parks at 0 rather than wrapping.
        if (cnt_q == 2'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd3;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign sr = data_q;

endmodule

// File: tb/tb_shiftrow256_seq.sv
// Bench for shiftrow256_seq: random states checked against a byte-level
// ShiftRows model, plus latency, backpressure, reset and throughput scenarios.
module tb_shiftrow256_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] sl;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] sr;

  int total = 0;
  int bad   = 0;

  shiftrow256_seq #(.NB(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sl        (sl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sr        (sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte i (0 = MSB) of each output row comes from byte i+off of
  // the input row (forward) or byte i-off (inverse), modulo 8.
  function automatic logic [255:0] ref_rows(input logic [255:0] s, input bit inverse);
    int offs [4];
    logic [7:0] b [8];
    logic [255:0] r;
    int k;
    offs[0] = 4; offs[1] = 3; offs[2] = 1; offs[3] = 0;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int i = 0; i < 8; i++) b[i] = s[64*row + 63 - 8*i -: 8];
      for (int i = 0; i < 8; i++) begin
        k = inverse ? (i - offs[row] + 8) % 8 : (i + offs[row]) % 8;
        r[64*row + 63 - 8*i -: 8] = b[k];
      end
    end
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Accept one state, wait (bounded) for out_valid, capture sr, then handshake.
  task automatic run_op(input logic [255:0] s, output logic [255:0] res, output int lat);
    sl = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res = sr;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sl = '0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sr !== 256'h0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sr=%h, want 1 0 0", in_ready, out_valid, sr);
    end
    tick();
    tick();
    rst = 1'b0;
    sl = rand256();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL first_accept: in_ready=%b after first edge, want 0", in_ready);
    end
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (out_valid !== 1'b1 || sr !== ref_rows(sl, 1'b0)) begin
      bad++;
      $display("FAIL first_accept_result: out_valid=%b sr=%h, want 1 %h", out_valid, sr, ref_rows(sl, 1'b0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_vector();
    logic [255:0] res;
    logic [255:0] exp_v;
    int lat;
    exp_v = 256'h8e9f01c6d54d01c6_dc01c6d57e01c64d_c6d7bd01c6a15801_d6f801c6bc9d01c6;
    run_op(256'h8e9f01c6d54d01c6_4ddc01c6d57e01c6_a15801c6d7bd01c6_bc9d01c6d6f801c6, res, lat);
    total++;
    if (res !== exp_v) begin
      bad++;
      $display("FAIL vector_data: got %h want %h", res, exp_v);
    end
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL vector_latency: out_valid after edge %0d, want 5", lat);
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL vector_return_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_roundtrip();
    logic [255:0] s, res;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      s = rand256();
      run_op(s, res, lat);
      total++;
      if (res !== ref_rows(s, 1'b0) || lat !== 5) begin
        bad++;
        $display("FAIL roundtrip_fwd[%0d]: got %h lat=%0d want %h lat=5", n, res, lat, ref_rows(s, 1'b0));
      end
      total++;
      if (ref_rows(res, 1'b1) !== s) begin
        bad++;
        $display("FAIL roundtrip_inv[%0d]: inverse %h want %h", n, ref_rows(res, 1'b1), s);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] s, exp_v;
    int errs;
    int wait_cnt;
    s = rand256();
    exp_v = ref_rows(s, 1'b0);
    sl = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      sl = rand256();
      in_valid = i[0];
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sr !== exp_v) errs++;
    end
    in_valid = 1'b0;
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL backpressure_hold: %0d of 20 cycles wrong, sr=%h want %h", errs, sr, exp_v);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    sl = rand256();
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sr !== 256'h0) begin
      bad++;
      $display("FAIL reset_mid_immediate: in_ready=%b out_valid=%b sr=%h, want 1 0 0", in_ready, out_valid, sr);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick();
    end
    out_ready = 1'b0;
    total++;
    if (seen !== 0 || sr !== 256'h0) begin
      bad++;
      $display("FAIL reset_mid_discard: out_valid seen %0d cycles sr=%h, want 0 and 0", seen, sr);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] a, b;
    logic [255:0] res [4];
    int acc_e [4];
    int hs_e [4];
    int nacc, nres;
    a = rand256();
    b = rand256();
    nacc = 0;
    nres = 0;
    sl = a;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      if (in_valid && in_ready && nacc < 4) begin
        acc_e[nacc] = e;
        nacc++;
      end
      if (out_valid && nres < 4) begin
        res[nres] = sr;
        hs_e[nres] = e;
        nres++;
      end
      tick();
      if (nacc == 1) sl = b;
      if (nacc >= 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (nacc !== 2 || acc_e[0] !== 1 || acc_e[1] !== 7) begin
      bad++;
      $display("FAIL b2b_accepts: count=%0d edges %0d,%0d want 2 at 1,7", nacc, acc_e[0], acc_e[1]);
    end
    total++;
    if (nres !== 2 || hs_e[0] !== 6 || hs_e[1] !== 12) begin
      bad++;
      $display("FAIL b2b_handshakes: count=%0d edges %0d,%0d want 2 at 6,12", nres, hs_e[0], hs_e[1]);
    end
    total++;
    if (res[0] !== ref_rows(a, 1'b0) || res[1] !== ref_rows(b, 1'b0)) begin
      bad++;
      $display("FAIL b2b_data: got %h / %h want %h / %h", res[0], res[1], ref_rows(a, 1'b0), ref_rows(b, 1'b0));
    end
  endtask

  task automatic test_ignored_input();
    logic [255:0] a, res;
    int lat;
    a = rand256();
    sl = a;
    in_valid = 1'b1;
    tick();
    lat = 1;
    while (!out_valid && lat < 20) begin
      sl = rand256();
      in_valid = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    res = sr;
    total++;
    if (res !== ref_rows(a, 1'b0) || lat !== 5) begin
      bad++;
      $display("FAIL ignored_input: got %h lat=%0d want %h lat=5", res, lat, ref_rows(a, 1'b0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ignored_input_idle: in_ready=%b want 1", in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_roundtrip();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_ignored_input();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
